ysyx_22040632_mem: RTL and testbench
====================================

YSYX_22040632_MEM -- requirements
Module: ysyx_22040632_mem

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  EX presents an instruction.
REQ-005 ex_ready  out  1  block accepts; transfer when ex_valid&&ex_ready at clk edge.
REQ-006 ex_pc  in  32  instruction PC.
REQ-007 ex_alu_res  in  32  memory address for ld/st, else writeback data.
REQ-008 ex_st_data  in  32  store source (rs2).
REQ-009 ex_ld_en, ex_st_en  in  1 each  load / store flags.
REQ-010 ex_funct3  in  3  access size/sign.
REQ-011 ex_rd  in  5, ex_rd_wen  in  1  destination register and write enable.
REQ-012 ex_wen_csr  in  1, ex_csr_addr  in  12, ex_csr_wdata  in  32, ex_ecall  in  1, ex_mret  in  1, ex_quit  in  1  CSR/trap/exit sideband, carried unchanged.
REQ-013 dmem_req_valid  out  1, dmem_req_ready  in  1  request handshake.
REQ-014 dmem_addr  out  32 (word-aligned, [1:0]=0), dmem_wen  out  1, dmem_wdata  out  32, dmem_wmask  out  4  request payload.
REQ-015 dmem_rsp_valid  in  1, dmem_rdata  in  32  load response.
REQ-016 wb_valid  out  1  one-cycle pulse per retired instruction.
REQ-017 wb_pc, wb_data, wb_data_ld  out  32 each; wb_ld_en  out  1; wb_rd  out  5; wb_rd_wen  out  1; wb_misalign  out  1; CSR/trap/quit fields  out  same widths as REQ-012, prefixed wb_.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT; ex_ready=1 only in IDLE.
REQ-019 Non-memory op accepted at edge T: wb_* registered at T, wb_valid=1 during cycle T..T+1, state stays IDLE.
REQ-020 Memory op accepted: operands latched, IDLE->REQ; dmem_req_valid=1 exactly while in REQ, payload stable until dmem_req_ready.
REQ-021 REQ with dmem_req_ready=1: store retires (wb registers load, wb_valid pulses next cycle), ->IDLE; load ->WAIT.
REQ-022 WAIT with dmem_rsp_valid=1: wb_data_ld loaded from extended rdata, wb_valid pulses, ->IDLE; dmem_rsp_valid ignored outside WAIT.
REQ-023 Load extraction by addr[1:0]: 000 LB sign-ext byte; 001 LH sign-ext half (addr[1]); 010 LW full; 100 LBU, 101 LHU zero-ext; other funct3 returns 0.
REQ-024 Store: SB wmask=4'b0001<<addr[1:0], wdata=byte replicated x4; SH wmask=4'b0011<<{addr[1],1'b0}, wdata=half replicated x2; SW wmask=4'hF, wdata=st_data.
REQ-025 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no dmem request, retire as non-memory op with wb_misalign=1, wb_rd_wen=0.
REQ-026 ex_ld_en&&ex_st_en both set: treated as load, store ignored.
REQ-027 wb_rd_wen SHALL be 0 whenever wb_valid=0; wb_data=ex_alu_res for every op.
REQ-028 wb_quit pulses with wb_valid only; no instruction accepted while REQ/WAIT.
REQ-029 Throughput: one non-memory op per cycle back-to-back; memory ops minimum 2 cycles (store) / 3 cycles (load) occupancy.

Reset
REQ-030 rst asserted: state=IDLE, all wb_* =0, dmem_req_valid=0, ex_ready=1 after release.
REQ-031 rst mid-REQ/WAIT: in-flight op dropped, never retired; late dmem_rsp_valid after reset ignored.

Verification
REQ-032 ADD result 0x0000_0010, rd=5, rd_wen=1 -> next cycle wb_valid=1, wb_data=0x10, wb_rd=5, wb_rd_wen=1.
REQ-033 LB addr 0x8000_0003, rdata 0x80FF_0000 -> dmem_addr=0x8000_0000, wb_data_ld=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 SH addr 0x8000_0002, st_data 0x1234_ABCD, req_ready held 0 for 3 cycles -> payload stable, wmask=4'b1100, wdata=0xABCD_ABCD, wb_valid after ready.
REQ-035 LW addr 0x8000_0001 -> no dmem_req_valid, wb_misalign=1, wb_rd_wen=0 next cycle.
REQ-036 rst pulsed while in WAIT, then rsp_valid=1 -> no wb_valid, state IDLE, ex_ready=1.

Source files
------------

// File: rtl/ysyx_22040632_mem_if.sv
// Bus bundle around the MEM stage: EX issue side, data-memory request/response, WB retire side.
interface ysyx_22040632_mem_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned CSRW = 12;
  localparam int unsigned REGW = 5;

  // EX -> MEM
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_alu_res;
  logic [XLEN-1:0] ex_st_data;
  logic            ex_ld_en;
  logic            ex_st_en;
  logic [2:0]      ex_funct3;
  logic [REGW-1:0] ex_rd;
  logic            ex_rd_wen;
  logic            ex_wen_csr;
  logic [CSRW-1:0] ex_csr_addr;
  logic [XLEN-1:0] ex_csr_wdata;
  logic            ex_ecall;
  logic            ex_mret;
  logic            ex_quit;

  // MEM <-> data memory
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_wen;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wmask;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;

  // MEM -> WB
  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] wb_data_ld;
  logic            wb_ld_en;
  logic [REGW-1:0] wb_rd;
  logic            wb_rd_wen;
  logic            wb_misalign;
  logic            wb_wen_csr;
  logic [CSRW-1:0] wb_csr_addr;
  logic [XLEN-1:0] wb_csr_wdata;
  logic            wb_ecall;
  logic            wb_mret;
  logic            wb_quit;

  // View of the MEM stage itself
  modport slave (
    input  ex_valid, ex_pc, ex_alu_res, ex_st_data, ex_ld_en, ex_st_en, ex_funct3,
           ex_rd, ex_rd_wen, ex_wen_csr, ex_csr_addr, ex_csr_wdata, ex_ecall, ex_mret, ex_quit,
           dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    output ex_ready,
           dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
           wb_valid, wb_pc, wb_data, wb_data_ld, wb_ld_en, wb_rd, wb_rd_wen, wb_misalign,
           wb_wen_csr, wb_csr_addr, wb_csr_wdata, wb_ecall, wb_mret, wb_quit
  );

  // View of the surrounding pipeline / memory that talks to the MEM stage
  modport master (
    output ex_valid, ex_pc, ex_alu_res, ex_st_data, ex_ld_en, ex_st_en, ex_funct3,
           ex_rd, ex_rd_wen, ex_wen_csr, ex_csr_addr, ex_csr_wdata, ex_ecall, ex_mret, ex_quit,
           dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    input  ex_ready,
           dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
           wb_valid, wb_pc, wb_data, wb_data_ld, wb_ld_en, wb_rd, wb_rd_wen, wb_misalign,
           wb_wen_csr, wb_csr_addr, wb_csr_wdata, wb_ecall, wb_mret, wb_quit
  );
endinterface

// File: rtl/ysyx_22040632_mem.sv
// MEM stage: passes ALU ops straight to WB, issues aligned loads/stores to data memory
// with a valid/ready request and a response pulse, and retires one WB pulse per instruction.
module ysyx_22040632_mem (
  input logic                clk,
  input logic                rst,
  ysyx_22040632_mem_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CSRW = 12;
  localparam int unsigned REGW = 5;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;

  // Operands of the memory op in flight
  logic [XLEN-1:0] op_pc;
  logic [XLEN-1:0] op_alu;
  logic [2:0]      op_funct3;
  logic [REGW-1:0] op_rd;
  logic            op_rd_wen;
  logic            op_ld;
  logic            op_wen_csr;
  logic [CSRW-1:0] op_csr_addr;
  logic [XLEN-1:0] op_csr_wdata;
  logic            op_ecall;
  logic            op_mret;
  logic            op_quit;

  logic            ex_is_ld_c;
  logic            ex_is_st_c;
  logic            ex_misalign_c;
  logic [3:0]      st_mask_c;
  logic [XLEN-1:0] st_wdata_c;

  // Sign/zero extension of the addressed byte/half out of the returned word
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                               input logic [1:0]      off,
                                               input logic [2:0]      f3);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rdata;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Decode of the op presented by EX: kind, alignment, store lane mask and data
  always_comb begin
    ex_is_ld_c    = bus.ex_ld_en;
    ex_is_st_c    = bus.ex_st_en & ~bus.ex_ld_en;
    ex_misalign_c = 1'b0;
    st_mask_c     = 4'b0000;
    st_wdata_c    = '0;
    if (ex_is_ld_c || ex_is_st_c) begin
      case (bus.ex_funct3)
        3'b001:  ex_misalign_c = bus.ex_alu_res[0];
        3'b101:  ex_misalign_c = ex_is_ld_c & bus.ex_alu_res[0];
        3'b010:  ex_misalign_c = |bus.ex_alu_res[1:0];
        default: ex_misalign_c = 1'b0;
      endcase
    end
    case (bus.ex_funct3)
      3'b000: begin
        st_mask_c  = 4'(4'b0001 << bus.ex_alu_res[1:0]);
        st_wdata_c = {4{bus.ex_st_data[7:0]}};
      end
      3'b001: begin
        st_mask_c  = 4'(4'b0011 << {bus.ex_alu_res[1], 1'b0});
        st_wdata_c = {2{bus.ex_st_data[15:0]}};
      end
      3'b010: begin
        st_mask_c  = 4'b1111;
        st_wdata_c = bus.ex_st_data;
      end
      default: begin
        st_mask_c  = 4'b0000;
        st_wdata_c = '0;
      end
    endcase
  end

  // Control FSM with registered handshake, request payload and WB outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      bus.ex_ready       <= 1'b1;
      bus.dmem_req_valid <= 1'b0;
      bus.dmem_addr      <= '0;
      bus.dmem_wen       <= 1'b0;
      bus.dmem_wdata     <= '0;
      bus.dmem_wmask     <= '0;
      bus.wb_valid       <= 1'b0;
      bus.wb_pc          <= '0;
      bus.wb_data        <= '0;
      bus.wb_data_ld     <= '0;
      bus.wb_ld_en       <= 1'b0;
      bus.wb_rd          <= '0;
      bus.wb_rd_wen      <= 1'b0;
      bus.wb_misalign    <= 1'b0;
      bus.wb_wen_csr     <= 1'b0;
      bus.wb_csr_addr    <= '0;
      bus.wb_csr_wdata   <= '0;
      bus.wb_ecall       <= 1'b0;
      bus.wb_mret        <= 1'b0;
      bus.wb_quit        <= 1'b0;
      op_pc              <= '0;
      op_alu             <= '0;
      op_funct3          <= '0;
      op_rd              <= '0;
      op_rd_wen          <= 1'b0;
      op_ld              <= 1'b0;
      op_wen_csr         <= 1'b0;
      op_csr_addr        <= '0;
      op_csr_wdata       <= '0;
      op_ecall           <= 1'b0;
      op_mret            <= 1'b0;
      op_quit            <= 1'b0;
    end else begin
      // Side-effecting WB strobes are single-cycle pulses
      bus.wb_valid   <= 1'b0;
      bus.wb_rd_wen  <= 1'b0;
      bus.wb_wen_csr <= 1'b0;
      bus.wb_ecall   <= 1'b0;
      bus.wb_mret    <= 1'b0;
      bus.wb_quit    <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.ex_valid) begin
            if ((ex_is_ld_c || ex_is_st_c) && !ex_misalign_c) begin
              op_pc              <= bus.ex_pc;
              op_alu             <= bus.ex_alu_res;
              op_funct3          <= bus.ex_funct3;
              op_rd              <= bus.ex_rd;
              op_rd_wen          <= bus.ex_rd_wen;
              op_ld              <= ex_is_ld_c;
              op_wen_csr         <= bus.ex_wen_csr;
              op_csr_addr        <= bus.ex_csr_addr;
              op_csr_wdata       <= bus.ex_csr_wdata;
              op_ecall           <= bus.ex_ecall;
              op_mret            <= bus.ex_mret;
              op_quit            <= bus.ex_quit;
              bus.dmem_req_valid <= 1'b1;
              bus.dmem_addr      <= {bus.ex_alu_res[XLEN-1:2], 2'b00};
              bus.dmem_wen       <= ex_is_st_c;
              bus.dmem_wdata     <= ex_is_st_c ? st_wdata_c : '0;
              bus.dmem_wmask     <= ex_is_st_c ? st_mask_c : 4'b0000;
              bus.ex_ready       <= 1'b0;
              state              <= REQ;
            end else begin
              // ALU op, or a misaligned access that never reaches memory
              bus.wb_valid     <= 1'b1;
              bus.wb_pc        <= bus.ex_pc;
              bus.wb_data      <= bus.ex_alu_res;
              bus.wb_data_ld   <= '0;
              bus.wb_ld_en     <= 1'b0;
              bus.wb_rd        <= bus.ex_rd;
              bus.wb_rd_wen    <= bus.ex_rd_wen & ~ex_misalign_c;
              bus.wb_misalign  <= ex_misalign_c;
              bus.wb_wen_csr   <= bus.ex_wen_csr;
              bus.wb_csr_addr  <= bus.ex_csr_addr;
              bus.wb_csr_wdata <= bus.ex_csr_wdata;
              bus.wb_ecall     <= bus.ex_ecall;
              bus.wb_mret      <= bus.ex_mret;
              bus.wb_quit      <= bus.ex_quit;
            end
          end
        end

        REQ: begin
          if (bus.dmem_req_ready) begin
            bus.dmem_req_valid <= 1'b0;
            if (op_ld) begin
              state <= WAIT;
            end else begin
              // Store completes once the request is taken
              bus.wb_valid     <= 1'b1;
              bus.wb_pc        <= op_pc;
              bus.wb_data      <= op_alu;
              bus.wb_data_ld   <= '0;
              bus.wb_ld_en     <= 1'b0;
              bus.wb_rd        <= op_rd;
              bus.wb_rd_wen    <= op_rd_wen;
              bus.wb_misalign  <= 1'b0;
              bus.wb_wen_csr   <= op_wen_csr;
              bus.wb_csr_addr  <= op_csr_addr;
              bus.wb_csr_wdata <= op_csr_wdata;
              bus.wb_ecall     <= op_ecall;
              bus.wb_mret      <= op_mret;
              bus.wb_quit      <= op_quit;
              bus.ex_ready     <= 1'b1;
              state            <= IDLE;
            end
          end
        end

        WAIT: begin
          if (bus.dmem_rsp_valid) begin
            bus.wb_valid     <= 1'b1;
            bus.wb_pc        <= op_pc;
            bus.wb_data      <= op_alu;
            bus.wb_data_ld   <= load_ext(bus.dmem_rdata, op_alu[1:0], op_funct3);
            bus.wb_ld_en     <= 1'b1;
            bus.wb_rd        <= op_rd;
            bus.wb_rd_wen    <= op_rd_wen;
            bus.wb_misalign  <= 1'b0;
            bus.wb_wen_csr   <= op_wen_csr;
            bus.wb_csr_addr  <= op_csr_addr;
            bus.wb_csr_wdata <= op_csr_wdata;
            bus.wb_ecall     <= op_ecall;
            bus.wb_mret      <= op_mret;
            bus.wb_quit      <= op_quit;
            bus.ex_ready     <= 1'b1;
            state            <= IDLE;
          end
        end

        default: begin
          bus.dmem_req_valid <= 1'b0;
          bus.ex_ready       <= 1'b1;
          state              <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040632_mem.sv
// Directed bench for the MEM stage: scoreboard of expected WB retirements plus
// cycle-accurate checks of the handshake and request payload.
module tb_ysyx_22040632_mem;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040632_mem_if bus ();

  ysyx_22040632_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] data_ld;
    logic        ld_en;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        misalign;
    logic        quit;
    logic [11:0] csr_addr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_ret = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load extraction, written from the byte/half lane rules
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] bs;
    logic [31:0] hs;
    bs = w >> (8 * {30'd0, a});
    hs = a[1] ? (w >> 16) : w;
    case (f3)
      3'b000:  return {{24{bs[7]}}, bs[7:0]};
      3'b001:  return {{16{hs[15]}}, hs[15:0]};
      3'b010:  return w;
      3'b100:  return {24'd0, bs[7:0]};
      3'b101:  return {16'd0, hs[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] data, input logic [31:0] dld,
                      input logic ld_en, input logic [4:0] rd, input logic rd_wen,
                      input logic mis, input logic quit);
    exp_t e;
    e.pc = pc; e.data = data; e.data_ld = dld; e.ld_en = ld_en; e.rd = rd;
    e.rd_wen = rd_wen; e.misalign = mis; e.quit = quit; e.csr_addr = pc[11:0];
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every WB pulse must match the oldest expected retirement
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.wb_valid) begin
        n_ret++;
        if (sb.size() == 0) begin
          chk("wb_unexpected", 32'(bus.wb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_pc", bus.wb_pc, e.pc);
          chk("wb_data", bus.wb_data, e.data);
          chk("wb_ld_en", 32'(bus.wb_ld_en), 32'(e.ld_en));
          if (e.ld_en) chk("wb_data_ld", bus.wb_data_ld, e.data_ld);
          chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
          chk("wb_rd_wen", 32'(bus.wb_rd_wen), 32'(e.rd_wen));
          chk("wb_misalign", 32'(bus.wb_misalign), 32'(e.misalign));
          chk("wb_quit", 32'(bus.wb_quit), 32'(e.quit));
          chk("wb_csr_addr", 32'(bus.wb_csr_addr), 32'(e.csr_addr));
          chk("wb_wen_csr", 32'(bus.wb_wen_csr), 32'd1);
        end
      end else begin
        chk("idle_rd_wen", 32'(bus.wb_rd_wen), 32'd0);
        chk("idle_quit", 32'(bus.wb_quit), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] st,
                          input logic ld, input logic stn, input logic [2:0] f3,
                          input logic [4:0] rd, input logic rdwen, input logic quit);
    bus.ex_valid     = 1'b1;
    bus.ex_pc        = pc;
    bus.ex_alu_res   = alu;
    bus.ex_st_data   = st;
    bus.ex_ld_en     = ld;
    bus.ex_st_en     = stn;
    bus.ex_funct3    = f3;
    bus.ex_rd        = rd;
    bus.ex_rd_wen    = rdwen;
    bus.ex_wen_csr   = 1'b1;
    bus.ex_csr_addr  = pc[11:0];
    bus.ex_csr_wdata = alu;
    bus.ex_ecall     = 1'b0;
    bus.ex_mret      = 1'b0;
    bus.ex_quit      = quit;
  endtask

  task automatic idle_in();
    bus.ex_valid = 1'b0;
    bus.ex_ld_en = 1'b0;
    bus.ex_st_en = 1'b0;
    bus.ex_quit  = 1'b0;
  endtask

  // Full load transaction: issue, request taken next cycle, response the cycle after
  task automatic mem_load(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [2:0] f3, input logic also_st, input logic [31:0] rdata,
                          input logic [31:0] exp_ld);
    drive_op(pc, addr, 32'hFFFF_FFFF, 1'b1, also_st, f3, 5'd9, 1'b1, 1'b0);
    chk({tag, "_ex_ready_idle"}, 32'(bus.ex_ready), 32'd1);
    push(pc, addr, exp_ld, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    idle_in();
    chk({tag, "_req_valid"}, 32'(bus.dmem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_req_wen"}, 32'(bus.dmem_wen), 32'd0);
    chk({tag, "_ex_ready_req"}, 32'(bus.ex_ready), 32'd0);
    bus.dmem_req_ready = 1'b1;
    step();
    bus.dmem_req_ready = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.dmem_req_valid), 32'd0);
    chk({tag, "_ex_ready_wait"}, 32'(bus.ex_ready), 32'd0);
    chk({tag, "_no_early_wb"}, 32'(bus.wb_valid), 32'd0);
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rdata     = rdata;
    step();
    bus.dmem_rsp_valid = 1'b0;
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, "_data_ld"}, bus.wb_data_ld, exp_ld);
    chk({tag, "_ex_ready_back"}, 32'(bus.ex_ready), 32'd1);
  endtask

  // Full store transaction with optional back-pressure on the request
  task automatic mem_store(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] st, input logic [2:0] f3, input int stall,
                           input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    drive_op(pc, addr, st, 1'b0, 1'b1, f3, 5'd0, 1'b0, 1'b0);
    push(pc, addr, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) bus.dmem_req_ready = 1'b1;
      else bus.dmem_rsp_valid = 1'b1;
      chk({tag, "_req_valid"}, 32'(bus.dmem_req_valid), 32'd1);
      chk({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
      chk({tag, "_wen"}, 32'(bus.dmem_wen), 32'd1);
      chk({tag, "_wmask"}, 32'(bus.dmem_wmask), 32'(exp_mask));
      chk({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
      step();
      bus.dmem_rsp_valid = 1'b0;
    end
    bus.dmem_req_ready = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.dmem_req_valid), 32'd0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, "_ex_ready"}, 32'(bus.ex_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;
    rst                = 1'b1;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rdata     = 32'd0;
    drive_op(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    idle_in();
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_req_valid", 32'(bus.dmem_req_valid), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_pc", bus.wb_pc, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_misalign", 32'(bus.wb_misalign), 32'd0);

    // ADD result 0x10 into x5
    drive_op(32'h8000_0000, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 1'b0);
    push(32'h8000_0000, 32'h0000_0010, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    idle_in();
    chk("add_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("add_wb_data", bus.wb_data, 32'h10);
    chk("add_wb_rd", 32'(bus.wb_rd), 32'd5);
    chk("add_wb_rd_wen", 32'(bus.wb_rd_wen), 32'd1);
    chk("add_no_req", 32'(bus.dmem_req_valid), 32'd0);
    step();
    chk("add_pulse_end", 32'(bus.wb_valid), 32'd0);

    // Three back-to-back ALU ops, last one carries quit
    r0 = n_ret;
    for (int i = 0; i < 3; i++) begin
      drive_op(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 32'd0, 1'b0, 1'b0, 3'd0,
               5'(i + 1), 1'b1, 1'(i == 2));
      push(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 32'd0, 1'b0, 5'(i + 1), 1'b1, 1'b0,
           1'(i == 2));
      step();
    end
    idle_in();
    step();
    chk("b2b_retired", 32'(n_ret - r0), 32'd3);

    // Loads of every size/sign
    mem_load("lb", 32'h200, 32'h8000_0003, 3'b000, 1'b0, 32'h80FF_0000, 32'hFFFF_FF80);
    mem_load("lbu", 32'h204, 32'h8000_0003, 3'b100, 1'b0, 32'h80FF_0000, 32'h0000_0080);
    mem_load("lh", 32'h208, 32'h8000_0022, 3'b001, 1'b0, 32'h8001_7FFF,
             ref_load(32'h8001_7FFF, 2'd2, 3'b001));
    mem_load("lhu", 32'h20C, 32'h8000_0020, 3'b101, 1'b0, 32'h8001_7FFF,
             ref_load(32'h8001_7FFF, 2'd0, 3'b101));
    mem_load("lb1", 32'h210, 32'h8000_0041, 3'b000, 1'b0, 32'h1234_5678,
             ref_load(32'h1234_5678, 2'd1, 3'b000));
    mem_load("lw", 32'h214, 32'h8000_0008, 3'b010, 1'b0, 32'hCAFE_F00D,
             ref_load(32'hCAFE_F00D, 2'd0, 3'b010));
    mem_load("ld_bad_f3", 32'h218, 32'h8000_0018, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd0);
    mem_load("ld_and_st", 32'h21C, 32'h8000_000C, 3'b010, 1'b1, 32'h0BAD_BEEF, 32'h0BAD_BEEF);

    // Stores; SH sees three cycles of back-pressure and stray rsp_valid
    mem_store("sh", 32'h300, 32'h8000_0002, 32'h1234_ABCD, 3'b001, 3, 4'b1100, 32'hABCD_ABCD);
    mem_store("sb", 32'h304, 32'h8000_0001, 32'h0000_00A5, 3'b000, 0, 4'b0010, 32'hA5A5_A5A5);
    mem_store("sw", 32'h308, 32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 1, 4'b1111, 32'hDEAD_BEEF);

    // EX holds a new op while a load is in flight; it must wait until IDLE
    drive_op(32'h400, 32'h8000_0010, 32'd0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1, 1'b0);
    push(32'h400, 32'h8000_0010, 32'h5555_AAAA, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    drive_op(32'h404, 32'h0000_0777, 32'd0, 1'b0, 1'b0, 3'd0, 5'd4, 1'b1, 1'b0);
    chk("busy_req_ready", 32'(bus.ex_ready), 32'd0);
    bus.dmem_req_ready = 1'b1;
    step();
    bus.dmem_req_ready = 1'b0;
    chk("busy_wait_ready", 32'(bus.ex_ready), 32'd0);
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rdata     = 32'h5555_AAAA;
    step();
    bus.dmem_rsp_valid = 1'b0;
    push(32'h404, 32'h0000_0777, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("busy_load_wb", 32'(bus.wb_valid), 32'd1);
    step();
    idle_in();
    chk("busy_held_wb", 32'(bus.wb_valid), 32'd1);
    chk("busy_held_data", bus.wb_data, 32'h777);
    step();

    // Misaligned accesses retire immediately without a memory request
    drive_op(32'h500, 32'h8000_0001, 32'd0, 1'b1, 1'b0, 3'b010, 5'd6, 1'b1, 1'b0);
    push(32'h500, 32'h8000_0001, 32'd0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
    chk("mis_lw_req", 32'(bus.dmem_req_valid), 32'd0);
    chk("mis_lw_flag", 32'(bus.wb_misalign), 32'd1);
    chk("mis_lw_rd_wen", 32'(bus.wb_rd_wen), 32'd0);
    chk("mis_lw_ready", 32'(bus.ex_ready), 32'd1);
    drive_op(32'h504, 32'h8000_0003, 32'h1111_2222, 1'b0, 1'b1, 3'b001, 5'd7, 1'b1, 1'b0);
    push(32'h504, 32'h8000_0003, 32'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
    chk("mis_sh_req", 32'(bus.dmem_req_valid), 32'd0);
    chk("mis_sh_flag", 32'(bus.wb_misalign), 32'd1);
    step();

    // Reset while waiting for a load response; the late response is ignored
    drive_op(32'h600, 32'h8000_0030, 32'd0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1, 1'b0);
    step();
    idle_in();
    bus.dmem_req_ready = 1'b1;
    step();
    bus.dmem_req_ready = 1'b0;
    chk("rstw_in_wait", 32'(bus.ex_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstw_req_valid", 32'(bus.dmem_req_valid), 32'd0);
    chk("rstw_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rstw_wb_pc", bus.wb_pc, 32'd0);
    step();
    rst = 1'b0;
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rdata     = 32'h7777_7777;
    step();
    bus.dmem_rsp_valid = 1'b0;
    chk("rstw_no_wb", 32'(bus.wb_valid), 32'd0);
    chk("rstw_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rstw_no_req", 32'(bus.dmem_req_valid), 32'd0);
    step();

    // Reset while a store request is pending
    drive_op(32'h700, 32'h8000_0040, 32'h1357_9BDF, 1'b0, 1'b1, 3'b010, 5'd0, 1'b0, 1'b0);
    step();
    idle_in();
    chk("rstq_req_valid", 32'(bus.dmem_req_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.dmem_req_ready = 1'b1;
    step();
    bus.dmem_req_ready = 1'b0;
    chk("rstq_no_wb", 32'(bus.wb_valid), 32'd0);
    chk("rstq_no_req", 32'(bus.dmem_req_valid), 32'd0);
    chk("rstq_ex_ready", 32'(bus.ex_ready), 32'd1);

    // Pipeline still works after reset
    drive_op(32'h800, 32'h0000_ABCD, 32'd0, 1'b0, 1'b0, 3'd0, 5'd10, 1'b1, 1'b1);
    push(32'h800, 32'h0000_ABCD, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
    step();
    idle_in();
    chk("post_wb_valid", 32'(bus.wb_valid), 32'd1);
    step();
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
